lsu: RTL and testbench

Load/store unit sitting directly upstream of the 256×8 data memory: it accepts one memory operation per cycle from the core datapath and drives the memory's address, write-data and write-enable. It also owns the hardware stack pointer (PUSH/POP), registers load results, and runs a multi-cycle CLEAR sequence that zeroes the whole memory.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/lsu_if.sv | 41 ++++
 rtl/lsu.sv | 152 +++++++++++++++
 tb/tb_lsu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the memory subsystem.
//            Contains the operation encoding, the LSU state encoding and the
//            stack geometry.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Operation codes on the core-to-LSU op channel. Encodings 6 and 7 are
  // unused and behave as NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CLEAR = 3'd5
  } mem_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lsu_state_t;

  // The stack occupies [STACK_BOTTOM, STACK_TOP] and grows downward.
  localparam logic [7:0] STACK_TOP    = 8'hFF;
  localparam logic [7:0] STACK_BOTTOM = 8'hC0;
  localparam int unsigned STACK_DEPTH = int'(STACK_TOP) - int'(STACK_BOTTOM) + 1;

  // The occupancy counter must represent both 0 and STACK_DEPTH.
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  // Address of the most recently pushed entry, given the next-free-slot SP.
  function automatic logic [7:0] sp_above(input logic [7:0] sp);
    return sp + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Purpose  : Bundle between the core datapath, the LSU and the data memory.
//   op_valid/op/op_addr/op_data -> operation request (core to LSU)
//   op_ready                    <- LSU can accept an operation
//   ld_data/ld_valid            <- load/pop result and its one-cycle pulse
//   sp/stk_err                  <- stack pointer and sticky stack error
//   mem_addr/mem_dat_out/mem_wr_en <- memory address, write data, write enable
//   mem_dat_in                  -> combinational memory read data
//   Modport master: the core/memory side. Modport slave: the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_if;
  logic       op_valid;
  logic [2:0] op;
  logic [7:0] op_addr;
  logic [7:0] op_data;
  logic       op_ready;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic [7:0] sp;
  logic       stk_err;
  logic [7:0] mem_addr;
  logic [7:0] mem_dat_out;
  logic       mem_wr_en;
  logic [7:0] mem_dat_in;

  modport master (
    output op_valid, op, op_addr, op_data, mem_dat_in,
    input  op_ready, ld_data, ld_valid, sp, stk_err,
    input  mem_addr, mem_dat_out, mem_wr_en
  );

  modport slave (
    input  op_valid, op, op_addr, op_data, mem_dat_in,
    output op_ready, ld_data, ld_valid, sp, stk_err,
    output mem_addr, mem_dat_out, mem_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit in front of a 256x8 data memory. Accepts one
//            operation per cycle (LOAD, STORE, PUSH, POP, CLEAR), owns the
//            hardware stack pointer, registers load results and sequences a
//            256-cycle memory clear.
// Ports    : clk   - clock, all state on rising edge
//            reset - synchronous active-high reset
//            bus   - lsu_if.slave (op channel, results, memory port)
// Revision : 1.0 - initial release
// ============================================================================
module lsu
  import mem_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  lsu_state_t       r_state;
  logic [7:0]       r_clr_addr;
  logic [7:0]       r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_ld_data;
  logic             r_ld_valid;
  logic             r_stk_err;

  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_sp_above;

  assign w_accept   = bus.op_valid && (r_state == ST_IDLE) && !reset;
  // Stack legality is judged by occupancy, never by SP wrap-around.
  assign w_full     = (r_cnt == CNT_W'(STACK_DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_sp_above = sp_above(r_sp);

  // --------------------------------------------------------------------------
  // Memory port: combinational from the accepted op (IDLE) or the clear
  // counter (CLEAR) so the memory writes on the accepting edge.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr    = 8'h00;
    bus.mem_dat_out = 8'h00;
    bus.mem_wr_en   = 1'b0;
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        bus.mem_addr  = r_clr_addr;
        bus.mem_wr_en = 1'b1;
      end else if (w_accept) begin
        case (bus.op)
          OP_LOAD: begin
            bus.mem_addr = bus.op_addr;
          end
          OP_STORE: begin
            bus.mem_addr    = bus.op_addr;
            bus.mem_dat_out = bus.op_data;
            bus.mem_wr_en   = 1'b1;
          end
          OP_PUSH: begin
            if (!w_full) begin
              bus.mem_addr    = r_sp;
              bus.mem_dat_out = bus.op_data;
              bus.mem_wr_en   = 1'b1;
            end
          end
          OP_POP: begin
            if (!w_empty) begin
              bus.mem_addr = w_sp_above;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= 8'h00;
      r_sp       <= STACK_TOP;
      r_cnt      <= '0;
      r_ld_data  <= 8'h00;
      r_ld_valid <= 1'b0;
      r_stk_err  <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.op)
              OP_LOAD: begin
                r_ld_data  <= bus.mem_dat_in;
                r_ld_valid <= 1'b1;
              end
              OP_PUSH: begin
                if (w_full) begin
                  r_stk_err <= 1'b1;
                end else begin
                  r_sp  <= r_sp - 8'd1;
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end
              OP_POP: begin
                r_ld_valid <= 1'b1;
                if (w_empty) begin
                  // Underflow still produces a (zero) result pulse.
                  r_ld_data <= 8'h00;
                  r_stk_err <= 1'b1;
                end else begin
                  r_ld_data <= bus.mem_dat_in;
                  r_sp      <= w_sp_above;
                  r_cnt     <= r_cnt - CNT_W'(1);
                end
              end
              OP_CLEAR: begin
                r_state    <= ST_CLEAR;
                r_clr_addr <= 8'h00;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 8'd1;
          if (r_clr_addr == 8'hFF) begin
            // Last zero write this cycle; the stack is empty afterwards.
            r_state   <= ST_IDLE;
            r_sp      <= STACK_TOP;
            r_cnt     <= '0;
            r_stk_err <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready = (r_state == ST_IDLE);
  assign bus.ld_data  = r_ld_data;
  assign bus.ld_valid = r_ld_valid;
  assign bus.sp       = r_sp;
  assign bus.stk_err  = r_stk_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu with a behavioural 256x8 memory,
//            a reference model of memory/stack state and a load scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // Behavioural data memory: combinational read, synchronous write.
  logic [7:0] mem [256];
  assign bus.mem_dat_in = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_dat_out;

  // Reference model
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp;
  int         ref_cnt;
  logic       ref_err;
  logic [7:0] sbq [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every ld_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.ld_valid) begin
      if (sbq.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
      else                 chk("ld_data", bus.ld_data, sbq.pop_front());
    end
  end

  task automatic model_reset();
    ref_sp  = 8'hFF;
    ref_cnt = 0;
    ref_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    sbq.delete();
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    logic       exp_wr;
    logic       is_ld;
    logic [7:0] exp_addr;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.op_addr  = a;
    bus.op_data  = d;
    exp_wr   = (op == OP_STORE) || (op == OP_PUSH && ref_cnt < 64);
    exp_addr = (op == OP_PUSH) ? ref_sp : a;
    is_ld    = (op == OP_LOAD) || (op == OP_POP);
    #1;
    chk("mem_wr_en", bus.mem_wr_en, exp_wr);
    if (exp_wr) begin
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("mem_dat_out", bus.mem_dat_out, d);
    end
    case (op)
      OP_LOAD:  sbq.push_back(ref_mem[a]);
      OP_STORE: ref_mem[a] = d;
      OP_PUSH: begin
        if (ref_cnt < 64) begin
          ref_mem[ref_sp] = d;
          ref_sp  = ref_sp - 8'd1;
          ref_cnt++;
        end else ref_err = 1'b1;
      end
      OP_POP: begin
        if (ref_cnt > 0) begin
          ref_sp = ref_sp + 8'd1;
          sbq.push_back(ref_mem[ref_sp]);
          ref_cnt--;
        end else begin
          sbq.push_back(8'h00);
          ref_err = 1'b1;
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    chk("ld_valid", bus.ld_valid, is_ld);
    chk("sp", bus.sp, ref_sp);
    chk("stk_err", bus.stk_err, ref_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.op_addr  = 8'h00;
    bus.op_data  = 8'h00;
    do_reset();

    // Reset state
    chk("rst_op_ready", bus.op_ready, 1'b1);
    chk("rst_sp", bus.sp, 8'hFF);
    chk("rst_stk_err", bus.stk_err, 1'b0);
    chk("rst_ld_valid", bus.ld_valid, 1'b0);
    chk("rst_ld_data", bus.ld_data, 8'h00);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);

    // POP on empty stack
    send(OP_POP, 8'h00, 8'h00);
    chk("underflow_err", bus.stk_err, 1'b1);
    chk("underflow_sp", bus.sp, 8'hFF);
    do_reset();

    // STORE then LOAD
    send(OP_STORE, 8'h10, 8'hA5);
    send(OP_LOAD, 8'h10, 8'h00);

    // PUSH, PUSH, POP, POP back-to-back
    send(OP_PUSH, 8'h00, 8'h11);
    send(OP_PUSH, 8'h00, 8'h22);
    chk("sp_two", bus.sp, 8'hFD);
    send(OP_POP, 8'h00, 8'h00);
    send(OP_POP, 8'h00, 8'h00);
    chk("sp_back", bus.sp, 8'hFF);
    chk("err_clean", bus.stk_err, 1'b0);

    // NOP and unused encoding do nothing
    send(3'd6, 8'h33, 8'h44);
    send(3'd7, 8'h34, 8'h45);
    send(OP_NOP, 8'h35, 8'h46);

    // Overflow: 64 pushes fill the stack, the 65th is rejected
    send(OP_STORE, 8'hBF, 8'h5A);
    for (int i = 0; i < 64; i++) send(OP_PUSH, 8'h00, 8'(i + 1));
    chk("full_sp", bus.sp, 8'hBF);
    send(OP_PUSH, 8'h00, 8'hEE);
    chk("ovf_err", bus.stk_err, 1'b1);
    chk("ovf_sp", bus.sp, 8'hBF);
    chk("ovf_mem", mem[8'hBF], 8'h5A);
    for (int i = 0; i < 64; i++) send(OP_POP, 8'h00, 8'h00);
    chk("drain_sp", bus.sp, 8'hFF);
    send(OP_PUSH, 8'h00, 8'h77);

    // Fill memory, then CLEAR
    for (int a = 0; a < 256; a++) send(OP_STORE, 8'(a), 8'(a) ^ 8'h3C);
    send(OP_LOAD, 8'h42, 8'h00);
    send(OP_CLEAR, 8'h00, 8'h00);
    n = 0;
    while (!bus.op_ready && n < 400) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("clr_cycles", n, 256);
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    model_reset();
    chk("clr_sp", bus.sp, 8'hFF);
    chk("clr_err", bus.stk_err, 1'b0);
    for (int a = 0; a < 256; a++) send(OP_LOAD, 8'(a), 8'h00);
    send(OP_PUSH, 8'h00, 8'h9A);
    send(OP_POP, 8'h00, 8'h00);

    // Reset in the middle of CLEAR
    send(OP_STORE, 8'h20, 8'hC3);
    send(OP_POP, 8'h00, 8'h00);
    send(OP_PUSH, 8'h00, 8'h5C);
    send(OP_LOAD, 8'h20, 8'h00);
    send(OP_CLEAR, 8'h00, 8'h00);
    chk("clr_busy", bus.op_ready, 1'b0);
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    chk("clr_wr_mid", bus.mem_wr_en, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_wr_in_clr", bus.mem_wr_en, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("mid_op_ready", bus.op_ready, 1'b1);
    chk("mid_sp", bus.sp, 8'hFF);
    chk("mid_err", bus.stk_err, 1'b0);
    chk("mid_ld_valid", bus.ld_valid, 1'b0);
    chk("mid_ld_data", bus.ld_data, 8'h00);
    chk("mid_wr_en", bus.mem_wr_en, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
